// File: rtl/ssd_demux_pkg.sv
// Shared types, constants and decode helpers for the seven-segment bus receiver.
package ssd_demux_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned ANODE_W   = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [ANODE_W-1:0] ANODE_D1    = 4'b0111;
    localparam logic [ANODE_W-1:0] ANODE_D2    = 4'b1011;
    localparam logic [ANODE_W-1:0] ANODE_D3    = 4'b1101;
    localparam logic [ANODE_W-1:0] ANODE_D4    = 4'b1110;
    localparam logic [ANODE_W-1:0] ANODE_BLANK = 4'b1111;

    // State name is the next slot the scan is expected to deliver.
    typedef enum logic [1:0] {
        WAIT_D1 = 2'd0,
        WAIT_D2 = 2'd1,
        WAIT_D3 = 2'd2,
        WAIT_D4 = 2'd3
    } state_e;

    // One sample of the display bus.
    typedef struct packed {
        logic [ANODE_W-1:0] anodes;
        logic [DIGIT_W-1:0] digit;
    } ssd_bus_t;

    localparam ssd_bus_t BUS_IDLE = '{anodes: ANODE_BLANK, digit: '0};

    // Anode pattern classification; slot is 0-based (0 = digit 1).
    typedef struct packed {
        logic              legal;
        logic              blank;
        logic [SLOT_W-1:0] slot;
    } anode_dec_t;

    // Classify a settled anode pattern.
    function automatic anode_dec_t decode_anodes(input logic [ANODE_W-1:0] anodes);
        anode_dec_t dec;
        dec = '0;
        case (anodes)
            ANODE_D1:    begin dec.legal = 1'b1; dec.slot = 2'd0; end
            ANODE_D2:    begin dec.legal = 1'b1; dec.slot = 2'd1; end
            ANODE_D3:    begin dec.legal = 1'b1; dec.slot = 2'd2; end
            ANODE_D4:    begin dec.legal = 1'b1; dec.slot = 2'd3; end
            ANODE_BLANK: dec.blank = 1'b1;
            default:     dec = '0;
        endcase
        return dec;
    endfunction

    // Slot index the FSM is waiting for.
    function automatic logic [SLOT_W-1:0] expected_slot(input state_e st);
        logic [SLOT_W-1:0] s;
        case (st)
            WAIT_D1: s = 2'd0;
            WAIT_D2: s = 2'd1;
            WAIT_D3: s = 2'd2;
            WAIT_D4: s = 2'd3;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    // Successor state after an in-order capture.
    function automatic state_e advance(input state_e st);
        state_e nx;
        case (st)
            WAIT_D1: nx = WAIT_D2;
            WAIT_D2: nx = WAIT_D3;
            WAIT_D3: nx = WAIT_D4;
            WAIT_D4: nx = WAIT_D1;
            default: nx = WAIT_D1;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/ssd_demux_sync_filter.sv
// Two-flop synchronizer, change detector and settle counter for the display bus.
module ssd_demux_sync_filter
    import ssd_demux_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  ssd_bus_t i_bus,
    output ssd_bus_t o_settled,
    output logic     o_settle_stb
);

    localparam int unsigned        CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    ssd_bus_t          sync1_q, sync1_d;
    ssd_bus_t          sync2_q, sync2_d;
    ssd_bus_t          prev_q, prev_d;
    ssd_bus_t          settled_q, settled_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stb_q, stb_d;
    logic              change;

    // Settle counting; the strobe fires on the single cycle the count reaches saturation.
    always_comb begin
        sync1_d   = i_bus;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        cnt_d     = cnt_q;
        stb_d     = 1'b0;
        settled_d = settled_q;
        change    = (sync2_q != prev_q);

        if (change) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!change && (cnt_q == CNT_LAST)) begin
            stb_d     = 1'b1;
            settled_d = prev_q;
        end
    end

    // Synchronizer, history and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= BUS_IDLE;
            sync2_q   <= BUS_IDLE;
            prev_q    <= BUS_IDLE;
            settled_q <= BUS_IDLE;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            settled_q <= settled_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
        end
    end

    assign o_settled    = settled_q;
    assign o_settle_stb = stb_q;

endmodule

// File: rtl/ssd_demux.sv
// Receive side of the scanned seven-segment bus: rebuilds digits and tracks frame order.
module ssd_demux
    import ssd_demux_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic [DIGIT_W-1:0] i_Digit,
    input  logic [ANODE_W-1:0] i_Anodes,
    output logic [DIGIT_W-1:0] o_Digit_1,
    output logic [DIGIT_W-1:0] o_Digit_2,
    output logic [DIGIT_W-1:0] o_Digit_3,
    output logic [DIGIT_W-1:0] o_Digit_4,
    output logic               o_Frame_Valid,
    output logic               o_Frame_Done,
    output logic               o_Seq_Err,
    output logic               o_Anode_Err,
    output logic               o_Timeout
);

    localparam int unsigned      TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    ssd_bus_t   bus_in;
    ssd_bus_t   settled;
    logic       settle_stb;

    assign bus_in = '{anodes: i_Anodes, digit: i_Digit};

    ssd_demux_sync_filter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_filter (
        .clk          (i_CLK),
        .rst          (i_RST),
        .i_bus        (bus_in),
        .o_settled    (settled),
        .o_settle_stb (settle_stb)
    );

    state_e                              state_q, state_d;
    logic [NUM_SLOTS-1:0][DIGIT_W-1:0]   digits_q, digits_d;
    logic [SLOT_W-1:0]                   last_slot_q, last_slot_d;
    logic                                last_vld_q, last_vld_d;
    logic [TMO_W-1:0]                    tmo_cnt_q, tmo_cnt_d;
    logic                                valid_q, valid_d;
    logic                                done_q, done_d;
    logic                                seq_err_q, seq_err_d;
    logic                                anode_err_q, anode_err_d;
    logic                                timeout_q, timeout_d;
    anode_dec_t                          dec;
    logic                                capture;

    // Decode, sequence FSM, digit capture and stale-scan timeout.
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        last_slot_d = last_slot_q;
        last_vld_d  = last_vld_q;
        tmo_cnt_d   = tmo_cnt_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        seq_err_d   = 1'b0;
        anode_err_d = 1'b0;
        timeout_d   = timeout_q;

        dec         = decode_anodes(settled.anodes);
        capture     = settle_stb && dec.legal;
        anode_err_d = settle_stb && !dec.legal && !dec.blank;

        if (capture) begin
            digits_d[dec.slot] = settled.digit;
            tmo_cnt_d          = '0;
            timeout_d          = 1'b0;
            last_slot_d        = dec.slot;
            last_vld_d         = 1'b1;

            if (dec.slot == expected_slot(state_q)) begin
                state_d = advance(state_q);
                if (state_q == WAIT_D4) begin
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end else if (dec.slot == 2'd0) begin
                // Slot 1 always restarts a frame; only a repeat of slot 1 is benign.
                state_d   = WAIT_D2;
                seq_err_d = !((state_q == WAIT_D2) && last_vld_q && (last_slot_q == 2'd0));
            end else if (last_vld_q && (dec.slot == last_slot_q)) begin
                state_d = state_q;
            end else begin
                state_d   = WAIT_D1;
                seq_err_d = 1'b1;
            end
        end else if (tmo_cnt_q == TMO_MAX) begin
            timeout_d = 1'b1;
            valid_d   = 1'b0;
            state_d   = WAIT_D1;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // State, digit and flag registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= WAIT_D1;
            digits_q    <= '0;
            last_slot_q <= '0;
            last_vld_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            seq_err_q   <= 1'b0;
            anode_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            last_slot_q <= last_slot_d;
            last_vld_q  <= last_vld_d;
            tmo_cnt_q   <= tmo_cnt_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            seq_err_q   <= seq_err_d;
            anode_err_q <= anode_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_Digit_1     = digits_q[0];
    assign o_Digit_2     = digits_q[1];
    assign o_Digit_3     = digits_q[2];
    assign o_Digit_4     = digits_q[3];
    assign o_Frame_Valid = valid_q;
    assign o_Frame_Done  = done_q;
    assign o_Seq_Err     = seq_err_q;
    assign o_Anode_Err   = anode_err_q;
    assign o_Timeout     = timeout_q;

endmodule

// File: tb/tb_ssd_demux.sv
// Self-checking bench for ssd_demux: dwell-level reference model plus directed literal checks.
module tb_ssd_demux;

    localparam int SETTLE = 4;
    localparam int TMO    = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an  = 4'hF;
    logic [3:0] dg  = 4'h0;

    logic [3:0] d1, d2, d3, d4;
    logic       valid, done, seq_err, aerr, tmo;
    logic [20:0] outs;

    assign outs = {d1, d2, d3, d4, valid, done, seq_err, aerr, tmo};

    ssd_demux #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_CLK         (clk),
        .i_RST         (rst),
        .i_Digit       (dg),
        .i_Anodes      (an),
        .o_Digit_1     (d1),
        .o_Digit_2     (d2),
        .o_Digit_3     (d3),
        .o_Digit_4     (d4),
        .o_Frame_Valid (valid),
        .o_Frame_Done  (done),
        .o_Seq_Err     (seq_err),
        .o_Anode_Err   (aerr),
        .o_Timeout     (tmo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_seq  = 0;
    int n_aerr = 0;

    // Reference model state: bus samples since reset, digits, expected slot, flags.
    logic [7:0] hist[$];
    int         edge_n;
    logic [3:0] m_dig[1:4];
    int         m_exp;
    int         m_last;
    int         m_lastcap;
    logic       m_valid, m_done, m_seq, m_aerr, m_tmo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Bus sample taken at edge idx (1 = first edge after reset); idle before that.
    function automatic logic [7:0] samp(input int idx);
        if (idx < 1) return 8'hF0;
        return hist[idx-1];
    endfunction

    task automatic model_reset();
        hist.delete();
        edge_n    = 0;
        m_exp     = 1;
        m_last    = 0;
        m_lastcap = 0;
        for (int i = 1; i <= 4; i++) m_dig[i] = 4'h0;
        m_valid = 1'b0; m_done = 1'b0; m_seq = 1'b0; m_aerr = 1'b0; m_tmo = 1'b0;
    endtask

    // A dwell starting at sample k and stable for SETTLE+1 samples is acted on at edge k+SETTLE+3.
    task automatic model_step();
        int         k;
        int         slot;
        bit         act;
        bit         cap;
        logic [7:0] v;
        edge_n++;
        hist.push_back({an, dg});
        m_done = 1'b0; m_seq = 1'b0; m_aerr = 1'b0;
        k   = edge_n - SETTLE - 3;
        act = 1'b0;
        cap = 1'b0;
        if (k >= 1 && samp(k) != samp(k-1)) begin
            act = 1'b1;
            for (int j = 1; j <= SETTLE; j++) if (samp(k+j) != samp(k)) act = 1'b0;
        end
        if (act) begin
            v = samp(k);
            case (v[7:4])
                4'b0111: slot = 1;
                4'b1011: slot = 2;
                4'b1101: slot = 3;
                4'b1110: slot = 4;
                4'b1111: slot = 0;
                default: begin slot = 0; m_aerr = 1'b1; end
            endcase
            if (slot != 0) begin
                cap         = 1'b1;
                m_dig[slot] = v[3:0];
                m_tmo       = 1'b0;
                m_lastcap   = edge_n;
                if (slot == m_exp) begin
                    if (m_exp == 4) begin m_done = 1'b1; m_valid = 1'b1; m_exp = 1; end
                    else m_exp = m_exp + 1;
                end else if (slot == 1) begin
                    if (!(m_exp == 2 && m_last == 1)) m_seq = 1'b1;
                    m_exp = 2;
                end else if (slot != m_last) begin
                    m_seq = 1'b1;
                    m_exp = 1;
                end
                m_last = slot;
            end
        end
        if (!cap && (edge_n - m_lastcap >= TMO)) begin
            m_tmo   = 1'b1;
            m_valid = 1'b0;
            m_exp   = 1;
        end
    endtask

    // Model advances on each clock edge, or resets.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Compare DUT against the model every cycle outside reset; tally pulses.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                check("outputs", 32'(outs),
                      32'({m_dig[1], m_dig[2], m_dig[3], m_dig[4], m_valid, m_done, m_seq, m_aerr, m_tmo}));
                if (done)    n_done++;
                if (seq_err) n_seq++;
                if (aerr)    n_aerr++;
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] d, input int n);
        an = a;
        dg = d;
        repeat (n) @(negedge clk);
    endtask

    int base;

    // Directed scenarios.
    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outs), 32'h0);
        rst = 1'b0;

        // Capture, then reset in the middle of the same dwell.
        drive(4'b0111, 4'h5, 12);
        check("first_capture", 32'(d1), 32'h5);
        rst = 1'b1;
        #1;
        check("reset_mid_dwell", 32'(outs), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check("no_early_capture", 32'(d1), 32'h0);
        @(negedge clk);
        check("capture_latency", 32'(d1), 32'h5);

        // In-order frame.
        base = n_done;
        drive(4'b0111, 4'h1, 10);
        drive(4'b1011, 4'h2, 10);
        drive(4'b1101, 4'h3, 10);
        drive(4'b1110, 4'h4, 10);
        check("frame_digits", 32'({d1, d2, d3, d4}), 32'h1234);
        check("frame_valid", 32'(valid), 32'h1);
        check("frame_done_count", 32'(n_done - base), 32'h1);

        // Short digit glitch is ignored, stable value captured.
        base = n_seq + n_aerr;
        drive(4'b0111, 4'h9, 2);
        drive(4'b0111, 4'h6, 10);
        check("glitch_digit", 32'(d1), 32'h6);
        check("glitch_no_errors", 32'(n_seq + n_aerr - base), 32'h0);

        // Illegal anode pattern pulses once per dwell; blank is silent.
        base = n_aerr;
        drive(4'b0011, 4'h1, 10);
        check("anode_err_count", 32'(n_aerr - base), 32'h1);
        check("anode_err_digits", 32'({d1, d2, d3, d4}), 32'h6234);
        base = n_aerr;
        drive(4'b1111, 4'h0, 10);
        check("blank_no_err", 32'(n_aerr - base), 32'h0);

        // Out-of-order capture.
        drive(4'b0111, 4'h7, 10);
        base = n_seq;
        drive(4'b1101, 4'h8, 10);
        check("seq_err_count", 32'(n_seq - base), 32'h1);
        check("seq_err_digit3", 32'(d3), 32'h8);
        check("seq_err_valid_kept", 32'(valid), 32'h1);

        // Complete a frame, then stall: timeout 50 cycles after the last capture.
        drive(4'b0111, 4'h1, 10);
        drive(4'b1011, 4'h2, 10);
        drive(4'b1101, 4'h3, 10);
        drive(4'b1110, 4'h4, 10);
        drive(4'b1111, 4'h0, 47);
        check("pre_timeout_flag", 32'(tmo), 32'h0);
        check("pre_timeout_valid", 32'(valid), 32'h1);
        @(negedge clk);
        check("timeout_flag", 32'(tmo), 32'h1);
        check("timeout_valid", 32'(valid), 32'h0);

        // Next capture clears the timeout.
        drive(4'b0111, 4'h3, 10);
        check("timeout_cleared", 32'(tmo), 32'h0);
        check("post_timeout_digit", 32'(d1), 32'h3);
        check("post_timeout_valid", 32'(valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
